// File: rtl/raw_hazard_unit.sv
// Operand hazard resolution for ID: EX/MEM/WB destination scoreboard, forwarding mux, load-use stall.
// Optional RAW_STALL_CNT_EN adds a saturating RAW_stall_cnt output.
module raw_hazard_unit #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LOAD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ID_valid,
  input  logic              ID_flush,
  input  logic [4:0]        ID_rs1_sel,
  input  logic [4:0]        ID_rs2_sel,
  input  logic              ID_rs1_used,
  input  logic              ID_rs2_used,
  input  logic [4:0]        ID_rd_sel,
  input  logic              ID_wr_en,
  input  logic              ID_is_load,
  input  logic [DATA_W-1:0] RGF_rs1_val,
  input  logic [DATA_W-1:0] RGF_rs2_val,
  input  logic [DATA_W-1:0] EX_rd_val,
  input  logic [DATA_W-1:0] MEM_rd_val,
  input  logic [DATA_W-1:0] WB_rd_val,
  output logic [4:0]        RAW_rs1_sel,
  output logic [4:0]        RAW_rs2_sel,
  output logic [DATA_W-1:0] RAW_rs1_val,
  output logic [DATA_W-1:0] RAW_rs2_val,
  output logic [1:0]        RAW_fwd1_src,
  output logic [1:0]        RAW_fwd2_src,
  output logic              RAW_stall
`ifdef RAW_STALL_CNT_EN
  ,
  output logic [31:0]       RAW_stall_cnt
`endif
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } slot_t;

  typedef enum logic [1:0] {
    SRC_RGF = 2'd0,
    SRC_EX  = 2'd1,
    SRC_MEM = 2'd2,
    SRC_WB  = 2'd3
  } src_e;

  slot_t ex_q, mem_q, wb_q;
  src_e  src1, src2;
  logic  haz1, haz2;

  // Youngest matching slot wins; haz flags a winning load whose data is not yet available.
  function automatic logic [2:0] resolve(input logic [4:0] sel, input logic used,
                                         input slot_t ex, input slot_t mem, input slot_t wb);
    logic [1:0] src;
    logic       haz;
    src = SRC_RGF;
    haz = 1'b0;
    if (used && sel != 5'd0) begin
      if (ex.v && ex.we && ex.rd == sel) begin
        src = SRC_EX;
        haz = ex.ld;
      end else if (mem.v && mem.we && mem.rd == sel) begin
        src = SRC_MEM;
        haz = mem.ld && (LOAD_LAT != 32'd1);
      end else if (wb.v && wb.we && wb.rd == sel) begin
        src = SRC_WB;
      end
    end
    return {haz, src};
  endfunction

  always_comb begin
    src1 = SRC_RGF;
    src2 = SRC_RGF;
    haz1 = 1'b0;
    haz2 = 1'b0;
    {haz1, src1} = resolve(ID_rs1_sel, ID_rs1_used, ex_q, mem_q, wb_q);
    {haz2, src2} = resolve(ID_rs2_sel, ID_rs2_used, ex_q, mem_q, wb_q);
  end

  always_comb begin
    RAW_rs1_val = '0;
    unique case (src1)
      SRC_EX:  RAW_rs1_val = EX_rd_val;
      SRC_MEM: RAW_rs1_val = MEM_rd_val;
      SRC_WB:  RAW_rs1_val = WB_rd_val;
      default: RAW_rs1_val = (ID_rs1_sel == 5'd0) ? '0 : RGF_rs1_val;
    endcase
  end

  always_comb begin
    RAW_rs2_val = '0;
    unique case (src2)
      SRC_EX:  RAW_rs2_val = EX_rd_val;
      SRC_MEM: RAW_rs2_val = MEM_rd_val;
      SRC_WB:  RAW_rs2_val = WB_rd_val;
      default: RAW_rs2_val = (ID_rs2_sel == 5'd0) ? '0 : RGF_rs2_val;
    endcase
  end

  assign RAW_rs1_sel  = ID_rs1_sel;
  assign RAW_rs2_sel  = ID_rs2_sel;
  assign RAW_fwd1_src = src1;
  assign RAW_fwd2_src = src2;
  assign RAW_stall    = ID_valid & ~ID_flush & (haz1 | haz2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= '{v:  ID_valid & ~ID_flush & ~RAW_stall,
                 rd: ID_rd_sel,
                 we: ID_wr_en,
                 ld: ID_is_load};
    end
  end

`ifdef RAW_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RAW_stall_cnt <= '0;
    end else if (RAW_stall && RAW_stall_cnt != '1) begin
      RAW_stall_cnt <= RAW_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/raw_hazard_unit.md
Name: raw_hazard_unit

Overview:
- Read-side partner of the register file. Sits in ID, drives the register file's rs1/rs2 read selects, and returns hazard-resolved operand values.
- Tracks in-flight destination registers in EX, MEM and WB.
- Forwards newer results ahead of stale register-file data.
- Stalls ID on load-use hazards.

Parameters:
DATA_W, 32, operand/result width
LOAD_LAT, 2, stage in which load data becomes forwardable: 1 = MEM, 2 = WB only

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ID_valid  input  1  ID holds a real instruction
ID_flush  input  1  squash ID instruction this cycle
ID_rs1_sel  input  5  source register 1
ID_rs2_sel  input  5  source register 2
ID_rs1_used  input  1  instruction reads rs1
ID_rs2_used  input  1  instruction reads rs2
ID_rd_sel  input  5  destination register
ID_wr_en  input  1  instruction writes rd
ID_is_load  input  1  instruction is a load
RGF_rs1_val  input  DATA_W  register file read data 1
RGF_rs2_val  input  DATA_W  register file read data 2
EX_rd_val  input  DATA_W  ALU result of the EX instruction
MEM_rd_val  input  DATA_W  result of the MEM instruction
WB_rd_val  input  DATA_W  value being written back this cycle
RAW_rs1_sel  output  5  register file read select 1 (= ID_rs1_sel, combinational)
RAW_rs2_sel  output  5  register file read select 2 (= ID_rs2_sel, combinational)
RAW_rs1_val  output  DATA_W  resolved operand 1
RAW_rs2_val  output  DATA_W  resolved operand 2
RAW_fwd1_src  output  2  0 = RGF, 1 = EX, 2 = MEM, 3 = WB
RAW_fwd2_src  output  2  same encoding for rs2
RAW_stall  output  1  hold IF/ID, bubble into EX

Behaviour:
- Reset: clk and rst_n as above; reset is asynchronous and active-low.
- Scoreboard: three slots (EX, MEM, WB), each holds {v, rd, we, ld}.
- rst_n low clears all slot v bits immediately. With all slots invalid:
  - RAW_stall = 0
  - fwd src = 0
  - RAW_rsX_val = RGF value
- Per rising edge:
  - WB <= MEM, MEM <= EX.
  - EX <= {ID_valid & ~ID_flush & ~RAW_stall, ID_rd_sel, ID_wr_en, ID_is_load}.
  - A stall therefore inserts exactly one bubble per stalled cycle.
- Slot match for operand X requires all of:
  - slot.v & slot.we
  - slot.rd == ID_rsX_sel
  - ID_rsX_sel != 0
  - ID_rsX_used
- Forward priority: EX > MEM > WB > RGF. The youngest match wins even if an older slot also matches.
- WB forwarding is required because the register file write lands only at the edge.
- rsX_sel == 0: value is 0 and src is 0, regardless of any slot contents.
- Load data readiness:
  - EX slot with ld: data is never ready.
  - MEM slot with ld: ready only if LOAD_LAT == 1.
  - WB slot with ld: always ready.
- Stall condition: RAW_stall = ID_valid & ~ID_flush & (any operand's highest-priority match is a load whose data is not ready).
  - Load-use stall lasts 1 cycle when LOAD_LAT = 1, 2 cycles when LOAD_LAT = 2.
- Value during a stall: RAW_rsX_val is don't-care, but must still be driven from the mux with no X.
- Flush vs stall: ID_flush has priority over stall. Flushed ID creates a bubble; RAW_stall = 0 that cycle.
- Reset mid-stall: scoreboard empties, stall drops asynchronously, no partial shift.
- Latency: forwarding paths are purely combinational; scoreboard state updates at 1 clock.

Optional Feature:
- Macro RAW_STALL_CNT_EN.
- Defined:
  - Adds output RAW_stall_cnt [31:0].
  - Increments on each rising edge with RAW_stall = 1; saturates at 0xFFFFFFFF.
  - Cleared to 0 by rst_n.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n = 0 with ID_valid = 1, rs1 = 5, RGF_rs1_val = 0x11 -> RAW_stall = 0, fwd1 = 0, RAW_rs1_val = 0x11; then asserting rst_n = 0 mid-stall drops RAW_stall without a clock.
- EX forward: cycle n issue rd = 5 ALU; cycle n+1 ID rs1 = 5, EX_rd_val = 0xAA, RGF = 0x11 -> fwd1 = 1, val = 0xAA, no stall.
- Priority/WB: rd = 7 writes in consecutive cycles, MEM = 0x22, WB = 0x33, ID rs2 = 7 -> fwd2 = 2, val = 0x22. With MEM slot not matching -> fwd2 = 3, val = 0x33.
- Load-use, LOAD_LAT = 2: load rd = 3, next instruction reads rs1 = 3 -> RAW_stall high for exactly 2 cycles, then fwd1 = 3 with WB_rd_val = 0xDEAD; two bubbles in EX. Same stimulus with LOAD_LAT = 1 -> 1 stall cycle, then fwd1 = 2.
- x0 and unused operands: EX slot rd = 0 writing, ID rs1 = 0 -> val = 0, src = 0. Matching rd with ID_rs2_used = 0 -> no forward, no stall.
- Flush and counter: load-use hazard with ID_flush = 1 -> RAW_stall = 0 and EX gets a bubble. With RAW_STALL_CNT_EN, the prior 2-cycle stall gives RAW_stall_cnt = 2.
